cntr_param: RTL and testbench

- Parametrised loadable up/down counter with an explicit state machine, exposing its state on o_state.
- Generalises the fixed 8-bit loadable counter:
  - WIDTH and STEP are parameters.
  - The counter has a programmable limit, a wrap or saturate mode, an enable, a synchronous clear, and terminal-count and wrap-event flags.
- Used as the general counting element in datapath and timer blocks.
- Structure: next-state/next-count logic, state and count registers, output logic.

---
 rtl/cntr_param_if.sv | 27 ++
 rtl/cntr_param.sv | 96 +++++++++
 tb/tb_cntr_param.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/cntr_param_if.sv
// Control/data bundle for the parametrised up/down counter.
// master drives controls and load/limit values; slave (the counter) returns count, state and flags.
interface cntr_param_if #(
   parameter int WIDTH = 8
);
   logic             clr;
   logic             load;
   logic             en;
   logic             inc;
   logic             sat;
   logic [WIDTH-1:0] d_in;
   logic [WIDTH-1:0] lim;
   logic [WIDTH-1:0] d_out;
   logic [2:0]       o_state;
   logic             tc;
   logic             wrp;

   modport master (
      output clr, load, en, inc, sat, d_in, lim,
      input  d_out, o_state, tc, wrp
   );

   modport slave (
      input  clr, load, en, inc, sat, d_in, lim,
      output d_out, o_state, tc, wrp
   );
endinterface

// File: rtl/cntr_param.sv
// Loadable up/down counter with programmable limit, wrap/saturate modes and an exposed FSM state.
// Latency: one clock from sampled controls to d_out/o_state/wrp; no backpressure, an update every enabled edge.
module cntr_param #(
   parameter int WIDTH = 8,
   parameter int STEP  = 1
) (
   input logic         clk,
   input logic         reset_n,
   cntr_param_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE = 3'b000,
      LOAD = 3'b001,
      INC  = 3'b010,
      DEC  = 3'b011,
      HOLD = 3'b100
   } state_t;

   localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
   localparam logic [WIDTH:0] ONE_X  = (WIDTH+1)'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             wrp_q, wrp_d;

   logic [WIDTH:0]   c_x, lim_x, m_x, sum_x, def_x, upd_x;
   logic             upd_wrp;

   // One extra bit keeps c+STEP and lim+1 exact for any legal STEP.
   always_comb begin
      c_x     = {1'b0, cnt_q};
      lim_x   = {1'b0, bus.lim};
      m_x     = lim_x + ONE_X;
      sum_x   = c_x + STEP_X;
      def_x   = STEP_X - c_x;
      upd_x   = '0;
      upd_wrp = 1'b0;
      if (c_x > lim_x) begin
         upd_x   = bus.sat ? lim_x : '0;
         upd_wrp = 1'b1;
      end else if (bus.inc) begin
         if (sum_x <= lim_x) begin
            upd_x = sum_x;
         end else begin
            upd_x   = bus.sat ? lim_x : (sum_x % m_x);
            upd_wrp = 1'b1;
         end
      end else begin
         if (c_x >= STEP_X) begin
            upd_x = c_x - STEP_X;
         end else begin
            // Borrow below zero: step back from M by the deficit, reduced modulo M.
            upd_x   = bus.sat ? '0 : ((m_x - (def_x % m_x)) % m_x);
            upd_wrp = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wrp_d   = 1'b0;
      if (bus.clr || (state_q > HOLD)) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (bus.load) begin
         state_d = LOAD;
         cnt_d   = (bus.d_in > bus.lim) ? bus.lim : bus.d_in;
         wrp_d   = (bus.d_in > bus.lim);
      end else if (bus.en) begin
         state_d = bus.inc ? INC : DEC;
         cnt_d   = WIDTH'(upd_x);
         wrp_d   = upd_wrp;
      end else if (state_q != IDLE) begin
         state_d = HOLD;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wrp_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wrp_q   <= wrp_d;
      end
   end

   assign bus.d_out   = cnt_q;
   assign bus.o_state = state_q;
   assign bus.wrp     = wrp_q;
   assign bus.tc      = ((state_q == INC) && (cnt_q == bus.lim)) ||
                        ((state_q == DEC) && (cnt_q == '0));
endmodule

// File: tb/tb_cntr_param.sv
// Bench for cntr_param: two instances (STEP=1, STEP=3) driven in lockstep and checked
// against an integer reference model, plus a vector table and directed corner sequences.
module tb_cntr_param;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   cntr_param_if #(.WIDTH(8)) if1 ();
   cntr_param_if #(.WIDTH(8)) if3 ();

   cntr_param #(.WIDTH(8), .STEP(1)) u_s1 (.clk(clk), .reset_n(reset_n), .bus(if1));
   cntr_param #(.WIDTH(8), .STEP(3)) u_s3 (.clk(clk), .reset_n(reset_n), .bus(if3));

   int n_chk = 0;
   int n_err = 0;

   // Reference model state, index 0 -> STEP=1, index 1 -> STEP=3
   int steps [2] = '{1, 3};
   int m_c   [2];
   int m_st  [2];
   int m_w   [2];
   int m_lim = 0;

   typedef struct {
      logic       clr, load, en, inc, sat;
      logic [7:0] din, lm;
      logic [7:0] e_d;
      logic [2:0] e_st;
      logic       e_w, e_tc;
   } vec_t;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int model_tc(input int k);
      return ((m_st[k] == 2 && m_c[k] == m_lim) || (m_st[k] == 3 && m_c[k] == 0)) ? 1 : 0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_c[k] = 0; m_st[k] = 0; m_w[k] = 0;
      end
   endtask

   task automatic model_edge(input int k, input int clr, input int load, input int en,
                             input int inc, input int sat, input int din, input int lm);
      int s, mm;
      s  = steps[k];
      mm = lm + 1;
      if (clr != 0) begin
         m_st[k] = 0; m_c[k] = 0; m_w[k] = 0;
      end else if (load != 0) begin
         m_st[k] = 1;
         m_w[k]  = (din > lm) ? 1 : 0;
         m_c[k]  = (din > lm) ? lm : din;
      end else if (en != 0) begin
         m_st[k] = (inc != 0) ? 2 : 3;
         if (m_c[k] > lm) begin
            m_c[k] = (sat != 0) ? lm : 0;
            m_w[k] = 1;
         end else if (inc != 0) begin
            if (m_c[k] + s <= lm) begin
               m_c[k] = m_c[k] + s; m_w[k] = 0;
            end else begin
               m_c[k] = (sat != 0) ? lm : (m_c[k] + s - mm) % mm;
               m_w[k] = 1;
            end
         end else begin
            if (m_c[k] >= s) begin
               m_c[k] = m_c[k] - s; m_w[k] = 0;
            end else begin
               m_c[k] = (sat != 0) ? 0 : (((m_c[k] + mm - s) % mm) + mm) % mm;
               m_w[k] = 1;
            end
         end
      end else begin
         m_st[k] = (m_st[k] == 0) ? 0 : 4;
         m_w[k]  = 0;
      end
   endtask

   task automatic compare_model(input string tag);
      chk({tag, "_s1_d"},  int'(if1.d_out),   m_c[0]);
      chk({tag, "_s1_st"}, int'(if1.o_state), m_st[0]);
      chk({tag, "_s1_w"},  int'(if1.wrp),     m_w[0]);
      chk({tag, "_s1_tc"}, int'(if1.tc),      model_tc(0));
      chk({tag, "_s3_d"},  int'(if3.d_out),   m_c[1]);
      chk({tag, "_s3_st"}, int'(if3.o_state), m_st[1]);
      chk({tag, "_s3_w"},  int'(if3.wrp),     m_w[1]);
      chk({tag, "_s3_tc"}, int'(if3.tc),      model_tc(1));
   endtask

   // Drive both instances, take one edge, advance the model, compare 1 time unit later.
   task automatic cyc(input string tag, input logic clr, input logic load, input logic en,
                      input logic inc, input logic sat, input logic [7:0] din, input logic [7:0] lm);
      if1.clr = clr; if1.load = load; if1.en = en; if1.inc = inc; if1.sat = sat;
      if1.d_in = din; if1.lim = lm;
      if3.clr = clr; if3.load = load; if3.en = en; if3.inc = inc; if3.sat = sat;
      if3.d_in = din; if3.lim = lm;
      @(posedge clk);
      m_lim = int'(lm);
      for (int k = 0; k < 2; k++)
         model_edge(k, int'(clr), int'(load), int'(en), int'(inc), int'(sat), int'(din), int'(lm));
      #1;
      compare_model(tag);
   endtask

   task automatic chk_s1(input string nm, input int d, input int st, input int w, input int tc);
      chk({nm, "_d"},  int'(if1.d_out),   d);
      chk({nm, "_st"}, int'(if1.o_state), st);
      chk({nm, "_w"},  int'(if1.wrp),     w);
      chk({nm, "_tc"}, int'(if1.tc),      tc);
   endtask

   vec_t tbl [20];

   initial begin
      //            clr load en inc sat din    lm     e_d    e_st    w  tc   (STEP=3 instance)
      tbl[0]  = '{0, 0, 0, 0, 0, 8'h00, 8'h09, 8'h00, 3'b000, 0, 0};
      tbl[1]  = '{0, 1, 0, 0, 0, 8'h55, 8'hC8, 8'h55, 3'b001, 0, 0};
      tbl[2]  = '{0, 1, 0, 0, 0, 8'hF0, 8'hC8, 8'hC8, 3'b001, 1, 0};
      tbl[3]  = '{0, 1, 0, 0, 0, 8'h07, 8'h09, 8'h07, 3'b001, 0, 0};
      tbl[4]  = '{0, 0, 1, 1, 0, 8'h00, 8'h09, 8'h00, 3'b010, 1, 0};
      tbl[5]  = '{0, 0, 1, 1, 0, 8'h00, 8'h09, 8'h03, 3'b010, 0, 0};
      tbl[6]  = '{0, 0, 1, 1, 0, 8'h00, 8'h09, 8'h06, 3'b010, 0, 0};
      tbl[7]  = '{0, 0, 1, 1, 0, 8'h00, 8'h09, 8'h09, 3'b010, 0, 1};
      tbl[8]  = '{0, 0, 1, 1, 0, 8'h00, 8'h09, 8'h02, 3'b010, 1, 0};
      tbl[9]  = '{1, 1, 1, 1, 0, 8'h05, 8'h09, 8'h00, 3'b000, 0, 0};
      tbl[10] = '{0, 1, 1, 1, 0, 8'h05, 8'h09, 8'h05, 3'b001, 0, 0};
      tbl[11] = '{0, 0, 0, 1, 0, 8'h00, 8'h09, 8'h05, 3'b100, 0, 0};
      tbl[12] = '{0, 0, 1, 1, 1, 8'h00, 8'h09, 8'h08, 3'b010, 0, 0};
      tbl[13] = '{0, 0, 1, 1, 1, 8'h00, 8'h09, 8'h09, 3'b010, 1, 1};
      tbl[14] = '{0, 0, 1, 0, 0, 8'h00, 8'h09, 8'h06, 3'b011, 0, 0};
      tbl[15] = '{0, 0, 1, 0, 0, 8'h00, 8'h09, 8'h03, 3'b011, 0, 0};
      tbl[16] = '{0, 0, 1, 0, 0, 8'h00, 8'h09, 8'h00, 3'b011, 0, 1};
      tbl[17] = '{0, 0, 1, 0, 0, 8'h00, 8'h09, 8'h07, 3'b011, 1, 0};
      tbl[18] = '{0, 0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 3'b010, 1, 1};
      tbl[19] = '{0, 0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 3'b010, 1, 1};

      if1.clr = 0; if1.load = 0; if1.en = 0; if1.inc = 0; if1.sat = 0; if1.d_in = 0; if1.lim = 0;
      if3.clr = 0; if3.load = 0; if3.en = 0; if3.inc = 0; if3.sat = 0; if3.d_in = 0; if3.lim = 0;
      model_reset();

      // Power-on reset
      repeat (2) @(posedge clk);
      #1;
      chk_s1("por", 0, 0, 0, 0);
      @(negedge clk);
      reset_n = 1'b1;

      // Asynchronous reset mid-count, observed before the next clock edge
      cyc("pre", 0, 1, 0, 0, 0, 8'h37, 8'hFF);
      chk_s1("mid", 8'h37, 1, 0, 0);
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      chk_s1("arst", 0, 0, 0, 0);
      chk("arst_s3_d", int'(if3.d_out), 0);
      @(negedge clk);
      reset_n = 1'b1;
      cyc("rel", 0, 0, 0, 0, 0, 8'h00, 8'h09);
      chk_s1("rel_idle", 0, 0, 0, 0);

      // Vector table against the STEP=3 instance
      foreach (tbl[i]) begin
         cyc($sformatf("tbl%0d", i), tbl[i].clr, tbl[i].load, tbl[i].en, tbl[i].inc,
             tbl[i].sat, tbl[i].din, tbl[i].lm);
         chk($sformatf("tbl%0d_d", i),  int'(if3.d_out),   int'(tbl[i].e_d));
         chk($sformatf("tbl%0d_st", i), int'(if3.o_state), int'(tbl[i].e_st));
         chk($sformatf("tbl%0d_w", i),  int'(if3.wrp),     int'(tbl[i].e_w));
         chk($sformatf("tbl%0d_tc", i), int'(if3.tc),      int'(tbl[i].e_tc));
      end

      // Saturating count-down on the STEP=1 instance
      cyc("sd0", 0, 1, 0, 0, 1, 8'h02, 8'h09);
      cyc("sd1", 0, 0, 1, 0, 1, 8'h00, 8'h09);
      chk_s1("sd1", 1, 3, 0, 0);
      cyc("sd2", 0, 0, 1, 0, 1, 8'h00, 8'h09);
      chk_s1("sd2", 0, 3, 0, 1);
      cyc("sd3", 0, 0, 1, 0, 1, 8'h00, 8'h09);
      chk_s1("sd3", 0, 3, 1, 1);
      cyc("sd4", 0, 0, 0, 0, 1, 8'h00, 8'h09);
      chk_s1("sd4", 0, 4, 0, 0);

      // Limit lowered below the current count, wrap then saturate
      cyc("ll0", 0, 1, 0, 0, 0, 8'h50, 8'hFF);
      cyc("ll1", 0, 0, 1, 0, 0, 8'h00, 8'h20);
      chk_s1("ll_wrap", 0, 3, 1, 1);
      cyc("ll2", 0, 1, 0, 0, 1, 8'h50, 8'hFF);
      cyc("ll3", 0, 0, 1, 0, 1, 8'h00, 8'h20);
      chk_s1("ll_sat", 8'h20, 3, 1, 0);

      // Randomised traffic against the reference model
      for (int n = 0; n < 400; n++) begin
         logic [7:0] lm_r;
         lm_r = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
         cyc($sformatf("rnd%0d", n),
             ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
             8'($urandom), lm_r);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
